// File: rtl/mips_fetch_queue_if.sv
// Handshake bundle between the IF stage (master) and the fetch queue (slave).
// The head entry and the occupancy are returned to the master side.
interface mips_fetch_queue_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/mips_fetch_queue.sv
// Instruction queue between IF and IF/ID: FWFT FIFO of {PC+4, inst} pairs with
// flush on taken branch, optional empty-queue bypass and occupancy output.
module mips_fetch_queue #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter bit          BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    mips_fetch_queue_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mips_fetch_queue: DEPTH must be a power of two >= 2");
    end

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic empty_c;
    logic full_c;
    logic bypass_c;
    logic out_valid_c;
    logic push_c;
    logic pop_c;
    logic store_c;
    logic take_c;

    // Handshake decode; bypass only forwards when storage is empty and no flush is pending.
    always_comb begin
        empty_c     = (count_q == '0);
        full_c      = (count_q == FULL_CNT);
        bypass_c    = BYPASS && empty_c && bus.in_valid && !flush && !rst;
        out_valid_c = BYPASS ? ((!empty_c || bypass_c) && !flush) : !empty_c;
        push_c      = bus.in_valid && !full_c && !rst;
        pop_c       = out_valid_c && bus.out_ready;
        // A bypassed entry that is consumed at once never touches storage.
        store_c     = push_c && !(bypass_c && bus.out_ready);
        take_c      = pop_c && !bypass_c;
    end

    // Pointer and occupancy next state; flush discards everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (take_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (store_c && !take_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (take_c && !store_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (store_c && !flush) begin
            pc_mem[wr_ptr_q]   <= bus.in_pc;
            inst_mem[wr_ptr_q] <= bus.in_inst;
        end
    end

    // Head is zeroed whenever invalid so stale storage never leaks out.
    always_comb begin
        bus.in_ready  = !full_c && !rst;
        bus.out_valid = out_valid_c;
        bus.count     = count_q;
        bus.out_pc    = '0;
        bus.out_inst  = '0;
        if (out_valid_c) begin
            if (bypass_c) begin
                bus.out_pc   = bus.in_pc;
                bus.out_inst = bus.in_inst;
            end else begin
                bus.out_pc   = pc_mem[rd_ptr_q];
                bus.out_inst = inst_mem[rd_ptr_q];
            end
        end
    end
endmodule
